// File: rtl/play_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | play_pkg : shared widths, state encoding and staged-frame descriptor for  |
// |            the double-buffered playback sequencer.                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package play_pkg;

    localparam int ADDR_W = 13;
    localparam int DIV_W  = 8;
    localparam int DROP_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] len;
        logic [DIV_W-1:0]  div;
    } frame_desc_t;

endpackage

`default_nettype wire

// File: rtl/play_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | play_ctrl_if : receiver-side frame handshake plus playback read port.      |
// | Revision     : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
interface play_ctrl_if;
    import play_pkg::*;

    logic              rx_busy;
    logic              frame_end;
    logic [ADDR_W-1:0] frame_len;
    logic [DIV_W-1:0]  frame_div;
    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic              playing;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output rx_busy, frame_end, frame_len, frame_div,
        input  wr_bank, rd_bank, rd_addr, rd_en, playing, drop_cnt
    );

    modport slave (
        input  rx_busy, frame_end, frame_len, frame_div,
        output wr_bank, rd_bank, rd_addr, rd_en, playing, drop_cnt
    );

endinterface

`default_nettype wire

// File: rtl/play_ctrl_rate_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rate_tick : loadable down-counter; registered tick the cycle after a       |
// |             restart, then one tick every div+1 clocks.                     |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module rate_tick
    import play_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             restart,
    input  wire logic [DIV_W-1:0] div,
    output logic                  tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;

    // Reload happens on the edge that closes a tick cycle, so a div sampled
    // there (possibly a freshly swapped one) sets the spacing to the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (restart) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else if (r_tick) begin
            r_cnt  <= div;
            r_tick <= (div == '0);
        end else begin
            r_tick <= (r_cnt == DIV_W'(1));
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - DIV_W'(1);
            end
        end
    end

    assign tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/play_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | play_ctrl : double-buffered playback sequencer; swaps in a new frame only  |
// |             at a loop boundary. Option macro: PLAY_CTRL_DROP_CNT_EN.       |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module play_ctrl
    import play_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    play_ctrl_if.slave  bus
);

    state_t            r_state;
    logic              r_pend;
    frame_desc_t       r_stage;
    frame_desc_t       r_cur;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [ADDR_W-1:0] r_rd_addr;

    logic              w_tick;
    logic              w_swap_ok;
    logic              w_period_end;
    logic              w_swap;
    logic              w_restart;
    logic [DIV_W-1:0]  w_div;

    assign w_swap_ok    = r_pend && !bus.rx_busy && !bus.frame_end;
    assign w_period_end = (r_state == PLAY) && w_tick && (r_rd_addr == r_cur.len);
    assign w_restart    = (r_state == IDLE) && w_swap_ok;
    assign w_swap       = w_restart || (w_period_end && w_swap_ok);
    assign w_div        = w_swap ? r_stage.div : r_cur.div;

    rate_tick u_rate_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (w_restart),
        .div     (w_div),
        .tick    (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pend    <= 1'b0;
            r_stage   <= '0;
            r_cur     <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b1;
            r_rd_addr <= '0;
        end else begin
            // A swap is never taken alongside frame_end, so these cannot collide.
            if (bus.frame_end) begin
                r_stage <= {bus.frame_len, bus.frame_div};
                r_pend  <= 1'b1;
            end else if (w_swap) begin
                r_pend  <= 1'b0;
            end

            if (w_swap) begin
                r_rd_bank <= r_wr_bank;
                r_wr_bank <= ~r_wr_bank;
                r_cur     <= r_stage;
            end

            case (r_state)
                IDLE: begin
                    r_rd_addr <= '0;
                    if (w_swap) begin
                        r_state <= PLAY;
                    end
                end
                PLAY: begin
                    if (w_tick) begin
                        r_rd_addr <= (r_rd_addr == r_cur.len) ? '0 : r_rd_addr + ADDR_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef PLAY_CTRL_DROP_CNT_EN
    logic [DROP_W-1:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (bus.frame_end && r_pend && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

    assign bus.drop_cnt = r_drop_cnt;
`else
    assign bus.drop_cnt = '0;
`endif

    assign bus.wr_bank = r_wr_bank;
    assign bus.rd_bank = r_rd_bank;
    assign bus.rd_addr = r_rd_addr;
    assign bus.rd_en   = w_tick;
    assign bus.playing = (r_state == PLAY);

endmodule

`default_nettype wire

// File: tb/tb_play_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_play_ctrl : scoreboard bench for play_ctrl; expected reads are queued   |
// |                by the stimulus and popped by a monitor on each rd_en.      |
// | Revision     : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
module tb_play_ctrl;

`ifdef PLAY_CTRL_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef struct {
        logic        bank;
        logic [12:0] addr;
        int          gap;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    rd_exp_t q[$];

    play_ctrl_if bus();

    play_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every read strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && bus.rd_en) begin
            n_checks++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got rd_en bank=%0d addr=%0d, required no read", bus.rd_bank, bus.rd_addr);
            end else begin
                rd_exp_t e;
                e = q.pop_front();
                if (bus.rd_bank !== e.bank || bus.rd_addr !== e.addr ||
                    (e.gap >= 0 && (cyc - last_cyc) != e.gap)) begin
                    n_err++;
                    $display("FAIL rd_seq: got bank=%0d addr=%0d gap=%0d, required bank=%0d addr=%0d gap=%0d",
                             bus.rd_bank, bus.rd_addr, cyc - last_cyc, e.bank, e.addr, e.gap);
                end
            end
            last_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic bank, input int len, input int div, input int n, input int first_gap);
        for (int i = 0; i < n; i++) begin
            rd_exp_t e;
            e.bank = bank;
            e.addr = 13'(i % (len + 1));
            e.gap  = (i == 0) ? first_gap : div + 1;
            q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.rx_busy   = 1'b0;
        bus.frame_end = 1'b0;
        bus.frame_len = '0;
        bus.frame_div = '0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic do_frame(input int len, input int div);
        bus.frame_len = 13'(len);
        bus.frame_div = 8'(div);
        bus.frame_end = 1'b1;
        step(1);
        bus.frame_end = 1'b0;
    endtask

    // Frame from IDLE, then one more edge: returns in the first PLAY cycle.
    task automatic start_frame(input int len, input int div);
        do_frame(len, div);
        step(1);
        check("playing_start", 32'(bus.playing), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int budget;
        budget = 300;
        while (q.size() != 0 && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: got %0d reads outstanding, required 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        do_reset();
        check("rst_wr_bank",  32'(bus.wr_bank),  32'd0);
        check("rst_rd_bank",  32'(bus.rd_bank),  32'd1);
        check("rst_rd_addr",  32'(bus.rd_addr),  32'd0);
        check("rst_rd_en",    32'(bus.rd_en),    32'd0);
        check("rst_playing",  32'(bus.playing),  32'd0);
        check("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);

        // 1: len=3 div=0, a read every clock
        push_seq(1'b0, 3, 0, 8, -1);
        start_frame(3, 0);
        check("t1_rd_bank", 32'(bus.rd_bank), 32'd0);
        check("t1_wr_bank", 32'(bus.wr_bank), 32'd1);
        wait_drain("t1");
        do_reset();

        // 2: second frame mid-period, swap at old frame's last address
        push_seq(1'b0, 3, 2, 4, -1);
        push_seq(1'b1, 1, 0, 4, 1);
        start_frame(3, 2);
        step(2);
        do_frame(1, 0);
        wait_drain("t2");
        check("t2_rd_bank", 32'(bus.rd_bank), 32'd1);
        check("t2_wr_bank", 32'(bus.wr_bank), 32'd0);
        do_reset();

        // 3: rx_busy held across a period end blocks the swap
        push_seq(1'b0, 1, 1, 6, -1);
        push_seq(1'b1, 2, 0, 4, 1);
        start_frame(1, 1);
        bus.rx_busy = 1'b1;
        do_frame(2, 0);
        step(6);
        check("t3_no_swap", 32'(bus.rd_bank), 32'd0);
        bus.rx_busy = 1'b0;
        wait_drain("t3");
        check("t3_rd_bank", 32'(bus.rd_bank), 32'd1);
        do_reset();

        // 4: two frames before a period end, latest wins
        push_seq(1'b0, 3, 3, 4, -1);
        push_seq(1'b1, 1, 0, 4, 1);
        start_frame(3, 3);
        step(1);
        do_frame(2, 1);
        step(1);
        do_frame(1, 0);
        check("t4_drop_cnt", 32'(bus.drop_cnt), DROP_EN ? 32'd1 : 32'd0);
        wait_drain("t4");
        do_reset();

        // 5: frame_end on a period end defers swap; new frame has len=0
        push_seq(1'b0, 1, 1, 6, -1);
        push_seq(1'b1, 0, 2, 3, 3);
        start_frame(1, 1);
        bus.rx_busy = 1'b1;
        do_frame(2, 0);
        step(5);
        bus.rx_busy = 1'b0;
        do_frame(0, 2);
        check("t5_deferred", 32'(bus.rd_bank), 32'd0);
        check("t5_drop_cnt", 32'(bus.drop_cnt), DROP_EN ? 32'd1 : 32'd0);
        wait_drain("t5");
        do_reset();

        // 5b: 65536 drops saturate the counter
        bus.rx_busy   = 1'b1;
        bus.frame_len = 13'd1;
        bus.frame_end = 1'b1;
        step(65537);
        bus.frame_end = 1'b0;
        check("t5_drop_sat", 32'(bus.drop_cnt), DROP_EN ? 32'h0000_FFFF : 32'd0);
        check("t5_sat_idle", 32'(bus.playing),  32'd0);
        do_reset();

        // 6: asynchronous reset in PLAY at rd_addr=2
        push_seq(1'b0, 5, 1, 3, -1);
        start_frame(5, 1);
        wait_drain("t6");
        check("t6_pre_addr", 32'(bus.rd_addr), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t6_wr_bank",  32'(bus.wr_bank),  32'd0);
        check("t6_rd_bank",  32'(bus.rd_bank),  32'd1);
        check("t6_rd_addr",  32'(bus.rd_addr),  32'd0);
        check("t6_rd_en",    32'(bus.rd_en),    32'd0);
        check("t6_playing",  32'(bus.playing),  32'd0);
        check("t6_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(10);
        check("t6_idle", 32'(bus.playing), 32'd0);
        push_seq(1'b0, 2, 0, 3, -1);
        start_frame(2, 0);
        wait_drain("t6b");
        do_reset();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
